// File: rtl/sqrt_range_reduce_pkg.sv
// Shared constants and FSM encoding for the sqrt range-reduction stage.
package sqrt_range_reduce_pkg;

    localparam int              X_W           = 11;
    localparam logic [X_W-1:0]  X_ONE         = 11'd512;
    localparam int              SQRT_LAT_DFLT = 3;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

endpackage

// File: rtl/sqrt_range_reduce_side_delay.sv
// Fixed-depth shift register aligning side-band data with the sqrt result.
module sqrt_side_delay #(
    parameter int W     = 7,
    parameter int DEPTH = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] stage [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++)
                stage[i] <= '0;
        end else begin
            stage[0] <= d;
            for (int unsigned i = 1; i < DEPTH; i++)
                stage[i] <= stage[i-1];
        end
    end

    assign q = stage[DEPTH-1];

endmodule

// File: rtl/sqrt_range_reduce.sv
// Normalises a variance word to a [1,4) 2Q9 mantissa plus even half-exponent.
// Define SQRT_RANGE_FAST_LZD_EN for single-cycle normalisation instead of the 2-bit/cycle scan.
module sqrt_range_reduce
    import sqrt_range_reduce_pkg::*;
#(
    parameter int VAR_W    = 32,
    parameter int VAR_FRAC = 16,
    parameter int SHIFT_W  = 5,
    parameter int SQRT_LAT = SQRT_LAT_DFLT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [VAR_W-1:0]   var_in,
    output logic [X_W-1:0]     x_2Q9,
    output logic               x_valid,
    output logic               sq_valid,
    output logic [SHIFT_W-1:0] sq_shift,
    output logic               sq_zero
);

    localparam int             P_W   = $clog2(VAR_W);
    localparam logic [P_W-1:0] P_TOP = P_W'(VAR_W - 2);

    state_t             state;
    logic [VAR_W-1:0]   work;
    logic [VAR_W-1:0]   scan_work;
    logic [P_W-1:0]     p;
    logic [P_W-1:0]     scan_p;
    logic [SHIFT_W-1:0] shift_r;
    logic [SHIFT_W-1:0] shift_next;
    logic               zero_r;
    logic               top_pair;
    logic [SHIFT_W+1:0] side_q;

`ifdef SQRT_RANGE_FAST_LZD_EN
    logic [P_W-1:0] lead_p;
    logic [P_W-1:0] norm_amt;

    // Jump straight to the state the iterative scan would reach, so the SCAN
    // decision logic below is shared and results stay bit-identical.
    always_comb begin
        lead_p = '0;
        for (int unsigned i = 0; i < VAR_W; i += 2)
            if (work[i +: 2] != 2'b00)
                lead_p = P_W'(i);
        norm_amt  = P_TOP - lead_p;
        scan_work = work << norm_amt;
        scan_p    = p - norm_amt;
    end
`else
    always_comb begin
        scan_work = work;
        scan_p    = p;
    end
`endif

    assign top_pair   = (scan_work[VAR_W-1 -: 2] != 2'b00);
    assign shift_next = SHIFT_W'((int'(scan_p) - VAR_FRAC) / 2);
    assign in_ready   = (state == ST_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            work    <= '0;
            p       <= '0;
            x_2Q9   <= '0;
            x_valid <= 1'b0;
            shift_r <= '0;
            zero_r  <= 1'b0;
        end else begin
            x_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        work  <= var_in;
                        p     <= P_TOP;
                        state <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (scan_work == '0) begin
                        x_2Q9   <= X_ONE;
                        shift_r <= '0;
                        zero_r  <= 1'b1;
                        x_valid <= 1'b1;
                        state   <= ST_IDLE;
                    end else if (top_pair) begin
                        x_2Q9   <= scan_work[VAR_W-1 -: X_W];
                        shift_r <= shift_next;
                        zero_r  <= 1'b0;
                        x_valid <= 1'b1;
                        state   <= ST_IDLE;
                    end else begin
                        work <= work << 2;
                        p    <= p - P_W'(2);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    sqrt_side_delay #(
        .W     (SHIFT_W + 2),
        .DEPTH (SQRT_LAT)
    ) u_side_delay (
        .clk   (clk),
        .reset (reset),
        .d     ({x_valid, shift_r, zero_r}),
        .q     (side_q)
    );

    assign {sq_valid, sq_shift, sq_zero} = side_q;

endmodule

// File: tb/tb_sqrt_range_reduce.sv
// Self-checking bench for sqrt_range_reduce; honours SQRT_RANGE_FAST_LZD_EN.
module tb_sqrt_range_reduce;

    localparam int LAT = 3;
`ifdef SQRT_RANGE_FAST_LZD_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] var_in;
    logic [10:0] x_2Q9;
    logic        x_valid;
    logic        sq_valid;
    logic [4:0]  sq_shift;
    logic        sq_zero;

    int checks = 0;
    int errors = 0;

    logic [31:0] words[$];
    int          acc_cyc[$];
    int          emit_cyc[$];
    logic [10:0] emit_x[$];
    int          sq_cyc[$];
    logic [4:0]  sq_sh[$];
    logic        sq_z[$];

    sqrt_range_reduce #(
        .VAR_W    (32),
        .VAR_FRAC (16),
        .SHIFT_W  (5),
        .SQRT_LAT (LAT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .var_in   (var_in),
        .x_2Q9    (x_2Q9),
        .x_valid  (x_valid),
        .sq_valid (sq_valid),
        .sq_shift (sq_shift),
        .sq_zero  (sq_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: value = m * 4^e with m in [1,4); mantissa truncated to 9 fraction bits.
    function automatic void model(input logic [31:0] v, output logic [10:0] x,
                                  output logic [4:0] sh, output logic z, output int lat);
        int msb;
        int pe;
        int s;
        if (v == 0) begin
            x = 11'd512; sh = 5'd0; z = 1'b1; lat = 1;
            return;
        end
        msb = $clog2(longint'(v) + 1) - 1;
        pe  = msb - (msb % 2);
        if (pe >= 9) x = 11'(v >> (pe - 9));
        else         x = 11'(v << (9 - pe));
        s   = (pe - 16) / 2;
        sh  = 5'(s);
        z   = 1'b0;
        lat = FAST ? 1 : (30 - pe) / 2 + 1;
    endfunction

    // Streams words[] with in_valid held high, records every event, then checks.
    task automatic run_seq(input string tag);
        int cyc = 0;
        int idx = 0;
        logic rdy;
        logic [10:0] ex;
        logic [4:0]  esh;
        logic        ez;
        int          elat;
        int          quiet;
        acc_cyc.delete(); emit_cyc.delete(); emit_x.delete();
        sq_cyc.delete();  sq_sh.delete();    sq_z.delete();
        in_valid = 1'b1;
        var_in   = words[0];
        while (sq_cyc.size() < words.size() && cyc < 300) begin
            rdy = in_ready;
            step();
            cyc++;
            if (in_valid && rdy) begin
                acc_cyc.push_back(cyc);
                idx++;
                if (idx < words.size()) var_in = words[idx];
                else begin in_valid = 1'b0; var_in = '0; end
            end
            if (x_valid) begin emit_cyc.push_back(cyc); emit_x.push_back(x_2Q9); end
            if (sq_valid) begin sq_cyc.push_back(cyc); sq_sh.push_back(sq_shift); sq_z.push_back(sq_zero); end
        end
        in_valid = 1'b0;
        check({tag, "_sq_count"}, 64'(sq_cyc.size()), 64'(words.size()));
        for (int i = 0; i < words.size(); i++) begin
            model(words[i], ex, esh, ez, elat);
            if (i < emit_cyc.size() && i < acc_cyc.size() && i < sq_cyc.size()) begin
                check($sformatf("%s_lat%0d", tag, i), 64'(emit_cyc[i] - acc_cyc[i]), 64'(elat));
                check($sformatf("%s_x%0d", tag, i), 64'(emit_x[i]), 64'(ex));
                check($sformatf("%s_sqdly%0d", tag, i), 64'(sq_cyc[i] - emit_cyc[i]), 64'(LAT));
                check($sformatf("%s_shift%0d", tag, i), 64'(sq_sh[i]), 64'(esh));
                check($sformatf("%s_zero%0d", tag, i), 64'(sq_z[i]), 64'(ez));
                if (i > 0)
                    check($sformatf("%s_nobubble%0d", tag, i), 64'(acc_cyc[i]), 64'(emit_cyc[i-1] + 1));
            end
        end
        quiet = 0;
        for (int k = 0; k < LAT + 2; k++) begin
            step();
            if (x_valid || sq_valid) quiet++;
        end
        check({tag, "_quiet_after"}, 64'(quiet), 64'd0);
    endtask

    initial begin
        int strobes;
        reset    = 1'b1;
        in_valid = 1'b0;
        var_in   = '0;
        repeat (3) step();

        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_x", 64'(x_2Q9), 64'd0);
        check("rst_x_valid", 64'(x_valid), 64'd0);
        check("rst_sq", 64'({sq_valid, sq_shift, sq_zero}), 64'd0);
        reset = 1'b0;
        step();

        words = '{32'h0001_0000};             run_seq("one");
        words = '{32'hC000_0000};             run_seq("three");
        words = '{32'h0000_0001};             run_seq("lsb");
        words = '{32'h0000_0000};             run_seq("zero");
        words = '{32'hFFFF_FFFF};             run_seq("allones");
        words = '{32'h0004_0000, 32'h0002_0000}; run_seq("b2b");

        for (int r = 0; r < 25; r++) begin
            int n;
            logic [31:0] w;
            words.delete();
            n = $urandom_range(1, 3);
            for (int j = 0; j < n; j++) begin
                w = $urandom >> $urandom_range(0, 31);
                if ($urandom_range(0, 9) == 0) w = '0;
                words.push_back(w);
            end
            run_seq($sformatf("rnd%0d", r));
        end

        // Reset landing between accept and the first scan edge aborts the word.
        in_valid = 1'b1;
        var_in   = 32'h0000_0001;
        step();
        in_valid = 1'b0;
        #2 reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        strobes = 0;
        for (int k = 0; k < 24; k++) begin
            step();
            if (x_valid || sq_valid) strobes++;
        end
        check("abort_strobes", 64'(strobes), 64'd0);
        check("abort_in_ready", 64'(in_ready), 64'd1);
        check("abort_x", 64'(x_2Q9), 64'd0);
        check("abort_sq", 64'({sq_valid, sq_shift, sq_zero}), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sqrt_range_reduce.md
# sqrt_range_reduce

Range-reduction stage directly upstream of the fixed-point [1,4) square-root approximator in the normalisation datapath. It accepts an unsigned fixed-point variance word and finds an even exponent so the mantissa lies in [1,4). It emits that mantissa as the 11-bit 2Q9 operand the sqrt stage consumes. It also carries the half-exponent and a zero flag through a delay line matched to the sqrt latency, so the downstream rescaler sees them aligned with the 1Q10 root.

## Interface
- VAR_W, 32: variance width; must be even and ≥ 12.
- VAR_FRAC, 16: fractional bits of the variance; must be even.
- SHIFT_W, 5: signed half-exponent width; must hold (VAR_W-2-VAR_FRAC)/2 and -VAR_FRAC/2.
- SQRT_LAT, 3: sqrt-stage latency in cycles, from operand to root.

- clk  in  1  clock; reset reset, asynchronous, active-high; clock clk.
- reset  in  1  asynchronous, active-high.
- in_valid  in  1  variance word valid.
- in_ready  out  1  block idle and able to accept.
- var_in  in  VAR_W  unsigned variance, UQ(VAR_W-VAR_FRAC).VAR_FRAC.
- x_2Q9  out  11  mantissa to sqrt stage, range [1,4).
- x_valid  out  1  one-cycle strobe; x_2Q9 is new this cycle.
- sq_valid  out  1  x_valid delayed SQRT_LAT cycles.
- sq_shift  out  SHIFT_W  signed half-exponent, delayed SQRT_LAT.
- sq_zero  out  1  input was zero, delayed SQRT_LAT.

## Operation
- FSM has two states, IDLE and SCAN. in_ready = (state==IDLE).
- Accept when in_valid && in_ready: work <= var_in, p <= VAR_W-2, go to SCAN.
- Each SCAN cycle evaluates in priority order:
  - If work==0: emit x_2Q9=512 (1.0), shift=0, zero=1.
  - Else if work[VAR_W-1:VAR_W-2]!=0: emit x_2Q9=work[VAR_W-1:VAR_W-11], shift=(p-VAR_FRAC)/2 as a signed value, zero=0.
  - Otherwise: work <= work<<2, p <= p-2, stay in SCAN.
- An emit registers the outputs, pulses x_valid, and returns to IDLE.
- Mantissa bits below the 11-bit window are truncated, not rounded. Relative error is ≤ 2^-9, within the sqrt stage's precision budget.
- x_2Q9 holds its last value between strobes.
- Delay line: x_valid, shift and zero pass through a SQRT_LAT-deep register chain with no enable, producing sq_*.
- There is no output backpressure, because the sqrt stage is a fixed pipeline.

## Timing
- Reset values: FSM IDLE, so in_ready=1. x_2Q9=0, x_valid=0, and every delay stage is 0, so sq_valid=0, sq_shift=0, sq_zero=0.
- Reset asserted mid-SCAN aborts the operation. No strobe is emitted for that word.
- Latency: accept at edge E0. The word shifts on edges E1..En, where n=(VAR_W-2-p_even)/2 and p_even is the leading-one index rounded down to even. The emit occurs on edge E(n+1).
- Zero input always emits on E1. Worst case is VAR_W/2 cycles.
- in_ready is high during the x_valid cycle, so a new word can be accepted with no bubble.
- sq_* is valid exactly SQRT_LAT cycles after x_valid, coincident with the sqrt result.

## Configuration
- SQRT_RANGE_FAST_LZD_EN defined: SCAN always completes in one cycle.
  - A combinational priority encoder finds p_even.
  - A barrel shift places the leading pair at [VAR_W-1:VAR_W-2].
  - Emit always occurs on E1, and outputs are bit-identical to the iterative mode.
- Undefined: the iterative 2-bit-per-cycle scan described above.

## Structure
- Shared package holds:
  - X_W=11 and X_ONE=11'd512;
  - default SQRT_LAT=3;
  - the FSM state enum.
- Sub-module sqrt_side_delay: parameterised-width, SQRT_LAT-deep shift register carrying {valid, shift, zero}.

## Test plan
- var_in=32'h0001_0000 (1.0) -> x_2Q9=512, shift=0, zero=0. x_valid 8 cycles after accept (iterative) or 1 cycle (fast). sq_valid 3 cycles after x_valid.
- var_in=32'hC000_0000 -> x_2Q9=1536 (3.0), shift=+7, x_valid on E1 in both modes.
- var_in=32'h0000_0001 -> x_2Q9=512, shift=-8 (5'b11000), x_valid on E16 (iterative).
- var_in=0 -> x_2Q9=512, shift=0, zero=1 on E1; sq_zero=1 three cycles later.
- in_valid held high with words 0x0004_0000, 0x0002_0000 -> accepted back-to-back with no idle cycle between emit and next accept. Results are x=512/shift=+1 then x=1024/shift=0. sq_* outputs stay aligned per word.
- reset pulsed during SCAN of 0x0000_0001 -> no x_valid, in_ready=1 after release, all sq_* outputs 0.
